// File: rtl/acq_controller.sv
// acq_controller: arms on start, fills a pre-trigger window, waits for a level/edge or
// auto trigger, then captures the post-trigger window into a circular RAM.
module acq_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int TO_WIDTH   = 16
) (
    input  logic                  clk_i,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] SI_data,
    input  logic                  SI_rdy,
    output logic                  SI_ack,
    input  logic                  start,
    input  logic                  stop,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic                  trig_rising,
    input  logic [ADDR_WIDTH:0]   pretrig_len,
    input  logic [ADDR_WIDTH:0]   num_samples,
    input  logic                  auto_en,
    input  logic [TO_WIDTH-1:0]   auto_timeout,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic                  trig_auto,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [2:0] {IDLE, PRETRIG, WAIT_TRIG, POSTTRIG, DONE} state_t;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
    localparam logic [TO_WIDTH-1:0]   TO_ONE  = 1;
    state_t                state;
    logic [ADDR_WIDTH:0]   ns_c, pl_c, pre_len, post_len, cnt;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [TO_WIDTH-1:0]   to_cnt, to_lat;
    logic [DATA_WIDTH-1:0] level_lat, prev;
    logic                  auto_lat, rising_lat, prev_valid, lvl_hit, auto_hit;

    assign SI_ack = SI_rdy;

    // Window lengths are normalised at arm time so num_samples=0 acts as 1 and the
    // post window is never empty.
    always_comb begin
        ns_c     = num_samples == '0 ? CNT_ONE : num_samples;
        pl_c     = pretrig_len >= ns_c ? ns_c - CNT_ONE : pretrig_len;
        lvl_hit  = prev_valid && (rising_lat ? (prev < level_lat && SI_data >= level_lat)
                                             : (prev > level_lat && SI_data <= level_lat));
        auto_hit = auto_lat && (to_lat == '0 || to_cnt + TO_ONE == to_lat);
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state      <= IDLE;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            trig_addr  <= '0;
            trig_auto  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            prev_valid <= 1'b0;
            prev       <= '0;
            ptr        <= '0;
            cnt        <= '0;
            to_cnt     <= '0;
            pre_len    <= '0;
            post_len   <= '0;
            to_lat     <= '0;
            level_lat  <= '0;
            auto_lat   <= 1'b0;
            rising_lat <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (stop) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else if (start && (state == IDLE || state == DONE)) begin
                state      <= pl_c == '0 ? WAIT_TRIG : PRETRIG;
                pre_len    <= pl_c;
                post_len   <= ns_c - pl_c;
                level_lat  <= trig_level;
                rising_lat <= trig_rising;
                auto_lat   <= auto_en;
                to_lat     <= auto_timeout;
                ptr        <= '0;
                cnt        <= '0;
                to_cnt     <= '0;
                prev_valid <= 1'b0;
                trig_auto  <= 1'b0;
                done       <= 1'b0;
                busy       <= 1'b1;
            end else if (busy && SI_rdy) begin
                wr_en      <= 1'b1;
                wr_addr    <= ptr;
                wr_data    <= SI_data;
                ptr        <= ptr + PTR_ONE;
                prev       <= SI_data;
                prev_valid <= 1'b1;
                cnt        <= cnt + CNT_ONE;
                if (state == PRETRIG) begin
                    if (cnt + CNT_ONE == pre_len) begin
                        state <= WAIT_TRIG;
                        cnt   <= '0;
                    end
                end else if (state == WAIT_TRIG) begin
                    to_cnt <= to_cnt + TO_ONE;
                    if (lvl_hit || auto_hit) begin
                        trig_addr <= ptr;
                        trig_auto <= !lvl_hit;
                        cnt       <= CNT_ONE;
                        state     <= post_len == CNT_ONE ? DONE : POSTTRIG;
                        busy      <= post_len != CNT_ONE;
                        done      <= post_len == CNT_ONE;
                    end
                end else if (cnt + CNT_ONE == post_len) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end
endmodule
